udp_fifo_pkt_sched: RTL and testbench

//  Read-side scheduler for the 2048x8b camera-to-UDP async FIFO. Runs in rd_clk only.

---
 rtl/udp_fifo_pkt_sched.sv | 148 ++++++++++++++
 tb/tb_udp_fifo_pkt_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_fifo_pkt_sched.sv
// Read-side packet scheduler for the camera-to-UDP async FIFO: launches full or flushed
// UDP packets and serves tx_req byte requests by popping the FIFO.
module udp_fifo_pkt_sched #(
    parameter int unsigned DEPTH_WIDTH   = 11,
    parameter int unsigned PKT_LEN       = 1024,
    parameter int unsigned LEN_WIDTH     = 16,
    parameter int unsigned FLUSH_TIMEOUT = 4095
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    output logic                 fifo_rd_en,
    input  logic [7:0]           fifo_rd_data,
    input  logic                 fifo_rd_empty,
    input  logic [DEPTH_WIDTH:0] fifo_rd_level,
    input  logic                 frame_end,
    output logic                 tx_start_en,
    output logic [LEN_WIDTH-1:0] tx_byte_num,
    input  logic                 tx_req,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [15:0]          pkt_cnt,
    output logic                 err_underrun
);
    localparam int unsigned LvlW = DEPTH_WIDTH + 1;
    localparam int unsigned TmrW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [LvlW-1:0] PktLenLvl = LvlW'(PKT_LEN);
    localparam logic [TmrW-1:0] TmrMax    = TmrW'(FLUSH_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StStart, StSend, StWaitDone} state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] remain_q, remain_d;
    logic [TmrW-1:0]      idle_tmr_q, idle_tmr_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 pop_q, pop_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;
    logic                 err_underrun_q, err_underrun_d;
    logic                 flush_clr;
    logic                 lvl_nz;
    logic                 lvl_full;

    assign lvl_nz   = (fifo_rd_level != '0);
    assign lvl_full = (fifo_rd_level >= PktLenLvl);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        remain_d       = remain_q;
        pop_d          = 1'b0;
        pkt_cnt_d      = pkt_cnt_q;
        err_underrun_d = err_underrun_q;
        flush_clr      = 1'b0;
        fifo_rd_en     = 1'b0;
        tx_start_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (lvl_full) begin
                    len_d   = LEN_WIDTH'(PKT_LEN);
                    state_d = StStart;
                end else if ((flush_pend_q || idle_tmr_q == TmrMax) && lvl_nz) begin
                    len_d     = LEN_WIDTH'(fifo_rd_level);
                    state_d   = StStart;
                    flush_clr = 1'b1;
                end
                if (!lvl_nz) begin
                    flush_clr = 1'b1;
                end
            end
            StStart: begin
                tx_start_en = 1'b1;
                remain_d    = len_q;
                state_d     = StSend;
            end
            StSend: begin
                // Underrun requests still consume a byte slot so the count tracks the UDP core.
                if (tx_req && remain_q != '0) begin
                    remain_d = remain_q - 1'b1;
                    if (fifo_rd_empty) begin
                        err_underrun_d = 1'b1;
                    end else begin
                        fifo_rd_en = 1'b1;
                        pop_d      = 1'b1;
                    end
                end
                if (tx_done) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = StIdle;
                end else if (remain_d == '0) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q == StIdle && lvl_nz && !lvl_full) begin
            idle_tmr_d = (idle_tmr_q == TmrMax) ? idle_tmr_q : idle_tmr_q + 1'b1;
        end else begin
            idle_tmr_d = '0;
        end

        if (frame_end) begin
            flush_pend_d = 1'b1;
        end else if (flush_clr) begin
            flush_pend_d = 1'b0;
        end else begin
            flush_pend_d = flush_pend_q;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q        <= StIdle;
            len_q          <= '0;
            remain_q       <= '0;
            idle_tmr_q     <= '0;
            flush_pend_q   <= 1'b0;
            pop_q          <= 1'b0;
            pkt_cnt_q      <= '0;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            remain_q       <= remain_d;
            idle_tmr_q     <= idle_tmr_d;
            flush_pend_q   <= flush_pend_d;
            pop_q          <= pop_d;
            pkt_cnt_q      <= pkt_cnt_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    // FIFO data arrives one cycle after the pop, so only the select is registered.
    assign tx_data      = pop_q ? fifo_rd_data : 8'h00;
    assign tx_byte_num  = len_q;
    assign busy         = (state_q != StIdle);
    assign pkt_cnt      = pkt_cnt_q;
    assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_udp_fifo_pkt_sched.sv
// Bench for udp_fifo_pkt_sched: FIFO and UDP-core models around the DUT, a cycle-level
// reference of the scheduling rules, a scenario table and hand-written corner sequences.
module tb_udp_fifo_pkt_sched;
    localparam int PKT_LEN = 1024;
    localparam int FLUSH_TIMEOUT = 4095;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_empty;
    logic [11:0] fifo_rd_level;
    logic        frame_end;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic        err_underrun;

    udp_fifo_pkt_sched #(
        .DEPTH_WIDTH  (11),
        .PKT_LEN      (PKT_LEN),
        .LEN_WIDTH    (16),
        .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_level(fifo_rd_level),
        .frame_end    (frame_end),
        .tx_start_en  (tx_start_en),
        .tx_byte_num  (tx_byte_num),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt),
        .err_underrun (err_underrun)
    );

    always #5 rd_clk = ~rd_clk;

    int total = 0;
    int bad = 0;

    // Environment: FIFO contents, write side and UDP core behaviour.
    logic [7:0] q_fifo[$];
    logic [7:0] rd_data_r = 8'h00;
    int  wr_left = 0;
    int  wr_val = 0;
    bit  wr_rand = 0;
    bit  req_rand = 0;
    int  udp_left = 0;
    int  udp_done_wait = -1;
    bit  fe_now = 0;
    bit  done_now = 0;
    int  force_lvl = -1;
    bit  force_empty = 0;
    int  dut_lens[$];

    // Reference scheduler state.
    bit         m_busy = 0;
    bit         m_start = 0;
    bit         m_send = 0;
    int         m_len = 0;
    int         m_remain = 0;
    int         m_tmr = 0;
    bit         m_flush = 0;
    int         m_pkts = 0;
    bit         m_err = 0;
    logic [7:0] m_txd = 8'h00;

    typedef struct {
        int nbytes;
        bit fe;
        bit rreq;
        int n;
        int l0;
        int l1;
        int l2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit quiet();
        return !m_busy && q_fifo.size() == 0 && wr_left == 0 && udp_left == 0 &&
               udp_done_wait < 0 && !fe_now;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_start = 0; m_send = 0; m_remain = 0; m_tmr = 0;
        m_flush = 0; m_pkts = 0; m_err = 0; m_txd = 8'h00;
        udp_left = 0; udp_done_wait = -1; done_now = 0; fe_now = 0;
    endtask

    // One rd_clk cycle: entered and left at posedge + 1.
    task automatic cycle();
        int lvl;
        bit emp;
        bit pop;
        bit under;
        bit fclr;
        int ntmr;
        lvl = (force_lvl >= 0) ? force_lvl : q_fifo.size();
        emp = force_empty || (q_fifo.size() == 0);
        fifo_rd_level = 12'(lvl);
        fifo_rd_empty = emp;
        fifo_rd_data  = rd_data_r;
        frame_end = fe_now;
        fe_now = 0;
        tx_req = 0;
        tx_done = 0;
        if (done_now) begin
            tx_done = 1; udp_left = 0; udp_done_wait = -1; done_now = 0;
        end else if (udp_left > 0) begin
            if (!req_rand || $urandom_range(3) != 0) begin
                tx_req = 1;
                udp_left--;
                if (udp_left == 0) udp_done_wait = $urandom_range(3);
            end
        end else if (udp_done_wait == 0) begin
            tx_done = 1; udp_done_wait = -1;
        end else if (udp_done_wait > 0) begin
            udp_done_wait--;
        end
        #1;
        pop   = m_send && tx_req && (m_remain > 0) && !emp;
        under = m_send && tx_req && (m_remain > 0) && emp;
        chk("tx_start_en", tx_start_en, m_start);
        chk("busy", busy, m_busy);
        chk("fifo_rd_en", fifo_rd_en, pop);
        chk("tx_data", tx_data, m_txd);
        chk("pkt_cnt", pkt_cnt, m_pkts % 65536);
        chk("err_underrun", err_underrun, m_err);
        if (m_busy) chk("tx_byte_num", tx_byte_num, m_len);
        if (tx_start_en === 1'b1) dut_lens.push_back(int'(tx_byte_num));

        ntmr = (!m_busy && lvl > 0 && lvl < PKT_LEN) ?
               ((m_tmr < FLUSH_TIMEOUT) ? m_tmr + 1 : m_tmr) : 0;
        fclr = 0;
        if (pop) begin
            rd_data_r = q_fifo.pop_front();
            m_txd = rd_data_r;
        end else begin
            m_txd = 8'h00;
        end
        if (!m_busy) begin
            if (lvl >= PKT_LEN) begin
                m_busy = 1; m_start = 1; m_len = PKT_LEN;
            end else if ((m_flush || m_tmr == FLUSH_TIMEOUT) && lvl != 0) begin
                m_busy = 1; m_start = 1; m_len = lvl; fclr = 1;
            end
            if (lvl == 0) fclr = 1;
        end else if (m_start) begin
            m_start = 0; m_send = 1; m_remain = m_len; udp_left = m_len;
        end else if (m_send) begin
            if (tx_req && m_remain > 0) m_remain--;
            if (under) m_err = 1;
            if (tx_done) begin
                m_send = 0; m_busy = 0; m_pkts++;
            end else if (m_remain == 0) begin
                m_send = 0;
            end
        end else if (tx_done) begin
            m_busy = 0; m_pkts++;
        end
        m_tmr = ntmr;
        if (frame_end) m_flush = 1;
        else if (fclr) m_flush = 0;

        if (wr_left > 0 && (!wr_rand || $urandom_range(1) == 1)) begin
            q_fifo.push_back(8'(wr_val));
            wr_val++;
            wr_left--;
        end
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_writes(input int max);
        for (int i = 0; i < max && wr_left > 0; i++) cycle();
        chk("writes_drained", wr_left, 0);
    endtask

    task automatic run_until_quiet(input int max);
        for (int i = 0; i < max && !quiet(); i++) cycle();
        chk("settled", quiet(), 1);
    endtask

    task automatic wait_sent(input int remain_at, input int max);
        for (int i = 0; i < max && !(m_send && m_remain <= remain_at); i++) cycle();
        chk("reached_send", busy, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int el[3];
        vecs[0] = '{nbytes: 1024, fe: 0, rreq: 0, n: 1, l0: 1024, l1: 0, l2: 0};
        vecs[1] = '{nbytes: 300,  fe: 1, rreq: 1, n: 1, l0: 300,  l1: 0, l2: 0};
        vecs[2] = '{nbytes: 2500, fe: 1, rreq: 1, n: 3, l0: 1024, l1: 1024, l2: 452};
        vecs[3] = '{nbytes: 10,   fe: 0, rreq: 1, n: 1, l0: 10,   l1: 0, l2: 0};

        rd_rst_n = 1'b0;
        fifo_rd_data = 8'h00;
        fifo_rd_empty = 1'b1;
        fifo_rd_level = '0;
        frame_end = 0;
        tx_req = 0;
        tx_done = 0;
        #3;
        chk("rst_tx_start_en", tx_start_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_byte_num", tx_byte_num, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err", err_underrun, 0);
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            dut_lens.delete();
            req_rand = vecs[v].rreq;
            wr_rand = 0;
            wr_left = vecs[v].nbytes;
            wait_writes(5000);
            if (vecs[v].fe) fe_now = 1;
            run_until_quiet(8000);
            el[0] = vecs[v].l0; el[1] = vecs[v].l1; el[2] = vecs[v].l2;
            chk("scenario_npkts", dut_lens.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n && i < dut_lens.size(); i++)
                chk("scenario_len", dut_lens[i], el[i]);
        end
        chk("pkt_cnt_after_table", pkt_cnt, 6);

        // Random write gaps, request gaps and frame_end pulses.
        wr_rand = 1;
        req_rand = 1;
        wr_left = 3000;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(599) == 0) fe_now = 1;
            cycle();
        end
        wait_writes(4000);
        fe_now = 1;
        run_until_quiet(8000);

        // tx_done arriving while still in SEND ends the packet.
        wr_rand = 0;
        req_rand = 0;
        dut_lens.delete();
        wr_left = 1024;
        wait_sent(1000, 3000);
        done_now = 1;
        cycle();
        chk("early_done_idle", busy, 0);
        fe_now = 1;
        run_until_quiet(3000);
        chk("early_done_npkts", dut_lens.size(), 2);
        if (dut_lens.size() == 2) chk("early_done_flush_len", dut_lens[1], 1000);

        // FIFO emptied externally mid-SEND while the level still reads full.
        wr_left = 1100;
        wait_sent(900, 3000);
        q_fifo.delete();
        force_lvl = 1500;
        force_empty = 1;
        for (int i = 0; i < 2000 && m_send; i++) cycle();
        chk("underrun_flag", err_underrun, 1);
        chk("underrun_still_busy", busy, 1);
        force_lvl = -1;
        force_empty = 0;
        run_until_quiet(3000);
        chk("underrun_sticky", err_underrun, 1);

        // Reset mid-SEND; the FIFO keeps its remaining bytes.
        dut_lens.delete();
        wr_left = 1100;
        wait_sent(1000, 3000);
        rd_rst_n = 1'b0;
        #1;
        chk("midrst_tx_start_en", tx_start_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fifo_rd_en", fifo_rd_en, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_tx_byte_num", tx_byte_num, 0);
        chk("midrst_pkt_cnt", pkt_cnt, 0);
        chk("midrst_err", err_underrun, 0);
        model_reset();
        dut_lens.delete();
        frame_end = 0;
        tx_req = 0;
        tx_done = 0;
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
        wait_writes(3000);
        fe_now = 1;
        run_until_quiet(4000);
        chk("post_rst_npkts", dut_lens.size(), 2);
        if (dut_lens.size() == 2) begin
            chk("post_rst_len0", dut_lens[0], 1024);
            chk("post_rst_len1", dut_lens[1], 52);
        end
        chk("post_rst_pkt_cnt", pkt_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
